audio_bus_arbiter: RTL

- Two-master Wishbone (classic, single-beat) arbiter sharing the psoc_audio register/FIFO slave between the neorv32 external bus (master 0) and an audio DMA/streaming engine (master 1).
- Sits between the CPU wrapper, the DMA engine and psoc_audio in fpga_soc_top.
- Round-robin grant; one transfer in flight; grant held until slave ack.

---
 rtl/audio_bus_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/audio_bus_arbiter.sv
// audio_bus_arbiter: two-master Wishbone classic arbiter in front of psoc_audio.
// Master 0 is the neorv32 external bus, master 1 the audio DMA/streaming engine.
// Round-robin between the two masters, one single-beat transfer in flight, and
// the grant is held until the slave acks. Every grant passes through IDLE, so a
// master holding stb continuously cannot take two transfers back to back.
// Optional feature: define AUDIO_ARB_TIMEOUT_EN to compile in a watchdog. It
// aborts a granted transfer with mX_err_o when the slave has not acked after
// TIMEOUT_CYCLES wait cycles.
module audio_bus_arbiter #(
    parameter int ADR_W          = 32,
    parameter int DAT_W          = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    // master 0
    input  logic [ADR_W-1:0]   m0_adr_i,
    input  logic [DAT_W-1:0]   m0_dat_i,
    output logic [DAT_W-1:0]   m0_dat_o,
    input  logic               m0_we_i,
    input  logic [DAT_W/8-1:0] m0_sel_i,
    input  logic               m0_stb_i,
    output logic               m0_ack_o,
    output logic               m0_err_o,
    // master 1
    input  logic [ADR_W-1:0]   m1_adr_i,
    input  logic [DAT_W-1:0]   m1_dat_i,
    output logic [DAT_W-1:0]   m1_dat_o,
    input  logic               m1_we_i,
    input  logic [DAT_W/8-1:0] m1_sel_i,
    input  logic               m1_stb_i,
    output logic               m1_ack_o,
    output logic               m1_err_o,
    // shared slave
    output logic [ADR_W-1:0]   s_adr_o,
    output logic [DAT_W-1:0]   s_dat_o,
    output logic               s_we_o,
    output logic [DAT_W/8-1:0] s_sel_o,
    output logic               s_stb_o,
    input  logic [DAT_W-1:0]   s_dat_i,
    input  logic               s_ack_i,
    // status
    output logic [1:0]         gnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state;
    logic   last_gnt;     // master served most recently; it loses the next tie
    logic   cur_stb;      // strobe of the currently granted master
    logic   timeout_hit;  // watchdog abort in this cycle

    // Strobe of whichever master currently owns the bus.
    always_comb begin
        // NOTE: assign every always_comb output a default first so that no path leaves it unassigned and infers a latch.
        cur_stb = 1'b0;
        if (state == GNT0) cur_stb = m0_stb_i;
        if (state == GNT1) cur_stb = m1_stb_i;
    end

`ifdef AUDIO_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] wait_cnt;

    // Count granted cycles without ack. IDLE always precedes a grant, so holding the count at zero there clears it on entry.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            wait_cnt <= '0;
        end else if (!s_ack_i) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Ack in the same cycle as the limit wins, so the abort requires ack low.
    assign timeout_hit = (state != IDLE) && cur_stb && !s_ack_i &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
    // Without the watchdog a hung slave keeps the grant indefinitely.
    assign timeout_hit = 1'b0;
`endif

    // Grant FSM: round-robin decision in IDLE, release on ack, stb drop or timeout.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values; blocking here would create order-dependent races.
        if (rst) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_stb_i && m1_stb_i) begin
                        state <= last_gnt ? GNT0 : GNT1;
                    end else if (m0_stb_i) begin
                        state <= GNT0;
                    end else if (m1_stb_i) begin
                        state <= GNT1;
                    end
                end
                GNT0, GNT1: begin
                    // A dropped stb ends the grant too; that master still counts as served.
                    if (s_ack_i || !cur_stb || timeout_hit) begin
                        state    <= IDLE;
                        last_gnt <= (state == GNT1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Route the granted master to the slave and the slave response back, same cycle.
    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_stb_o  = 1'b0;
        m0_dat_o = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        case (state)
            GNT0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_stb_o  = m0_stb_i && !timeout_hit;
                m0_dat_o = s_dat_i;
                m0_ack_o = s_ack_i && m0_stb_i;
                m0_err_o = timeout_hit;
            end
            GNT1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_stb_o  = m1_stb_i && !timeout_hit;
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i && m1_stb_i;
                m1_err_o = timeout_hit;
            end
            default: ;
        endcase
    end

    assign gnt_o = {state == GNT1, state == GNT0};

endmodule
